// File: rtl/addr_gen_unit_pkg.sv
// Shared types and encodings for the SLC-3 address-generation unit.
package slc3_agu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MREQ = 2'd2,
        DONE = 2'd3
    } agu_state_t;

    localparam logic [2:0] OFF_ZERO   = 3'd0;
    localparam logic [2:0] OFF_SEXT5  = 3'd1;
    localparam logic [2:0] OFF_SEXT6  = 3'd2;
    localparam logic [2:0] OFF_SEXT9  = 3'd3;
    localparam logic [2:0] OFF_SEXT11 = 3'd4;
    localparam logic [2:0] OFF_ZEXT8  = 3'd5;

    localparam logic BASE_PC  = 1'b0;
    localparam logic BASE_SR1 = 1'b1;

endpackage

// File: rtl/addr_gen_unit_offset_ext.sv
// IR offset-field extraction and sign/zero extension to DATA_W bits.
import slc3_agu_pkg::*;

module agu_offset_ext #(
    parameter int DATA_W = 16
) (
    input  logic [10:0]       ir_i,
    input  logic [2:0]        off_sel_i,
    output logic [DATA_W-1:0] offset_o
);

    always_comb begin
        offset_o = '0;
        case (off_sel_i)
            OFF_SEXT5:  offset_o = {{(DATA_W-5){ir_i[4]}},   ir_i[4:0]};
            OFF_SEXT6:  offset_o = {{(DATA_W-6){ir_i[5]}},   ir_i[5:0]};
            OFF_SEXT9:  offset_o = {{(DATA_W-9){ir_i[8]}},   ir_i[8:0]};
            OFF_SEXT11: offset_o = {{(DATA_W-11){ir_i[10]}}, ir_i[10:0]};
            OFF_ZEXT8:  offset_o = {{(DATA_W-8){1'b0}},      ir_i[7:0]};
            default:    offset_o = '0;
        endcase
    end

endmodule

// File: rtl/addr_gen_unit.sv
// Registered effective-address engine: base + IR offset, with optional
// pointer fetch (LDI/STI) over a timed-out memory-read handshake.
import slc3_agu_pkg::*;

module addr_gen_unit #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       IR,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] SR1,
    input  logic              base_sel,
    input  logic [2:0]        off_sel,
    input  logic              indirect,
    output logic              mem_rd_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    agu_state_t        state_q;
    logic              calc_ph_q;
    logic [10:0]       ir_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] sr1_q;
    logic              base_sel_q;
    logic [2:0]        off_sel_q;
    logic              ind_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;
    logic [7:0]        cnt_q;

    logic              in_ready_q;
    logic              out_valid_q;
    logic              mem_rd_req_q;
    logic              out_err_q;
    logic [DATA_W-1:0] out_addr_q;
    logic [DATA_W-1:0] mem_addr_q;

    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] base_val;
    logic              unused_ir_hi;

    // Only IR[10:0] feeds any offset field.
    assign unused_ir_hi = ^IR[15:11];

    agu_offset_ext #(
        .DATA_W(DATA_W)
    ) u_offset_ext (
        .ir_i      (ir_q),
        .off_sel_i (off_sel_q),
        .offset_o  (offset)
    );

    // Trap vectors are absolute: the base is forced to zero.
    always_comb begin
        base_val = '0;
        if (off_sel_q != OFF_ZEXT8) begin
            base_val = (base_sel_q == BASE_SR1) ? sr1_q : pc_q;
        end
        sum_d = base_val + offset;
    end

    // CALC spans two cycles: the first registers the sum, the second
    // dispatches from sum_q so every downstream output comes from a flop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            calc_ph_q    <= 1'b0;
            ir_q         <= '0;
            pc_q         <= '0;
            sr1_q        <= '0;
            base_sel_q   <= BASE_PC;
            off_sel_q    <= OFF_ZERO;
            ind_q        <= 1'b0;
            sum_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            mem_rd_req_q <= 1'b0;
            out_err_q    <= 1'b0;
            out_addr_q   <= '0;
            mem_addr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ir_q       <= IR[10:0];
                        pc_q       <= PC;
                        sr1_q      <= SR1;
                        base_sel_q <= base_sel;
                        off_sel_q  <= off_sel;
                        ind_q      <= indirect;
                        calc_ph_q  <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (!calc_ph_q) begin
                        sum_q     <= sum_d;
                        calc_ph_q <= 1'b1;
                    end else begin
                        calc_ph_q <= 1'b0;
                        cnt_q     <= '0;
                        if (ind_q) begin
                            mem_rd_req_q <= 1'b1;
                            mem_addr_q   <= sum_q;
                            state_q      <= MREQ;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_addr_q  <= sum_q;
                            out_err_q   <= 1'b0;
                            state_q     <= DONE;
                        end
                    end
                end
                MREQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Returned data takes priority over a coincident timeout.
                    if (mem_rd_valid) begin
                        mem_rd_req_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_addr_q   <= mem_rdata;
                        out_err_q    <= 1'b0;
                        state_q      <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_rd_req_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_addr_q   <= mem_addr_q;
                        out_err_q    <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign mem_rd_req = mem_rd_req_q;
    assign mem_addr   = mem_addr_q;
    assign out_addr   = out_addr_q;
    assign out_err    = out_err_q;

endmodule

// File: doc/addr_gen_unit.md
# addr_gen_unit

Parametrised, handshaked address-generation unit for the SLC-3 datapath. It replaces the purely combinational ADDR1/ADDR2 adder path with a registered effective-address (EA) engine. The engine adds a selectable base to a selectable IR-derived offset and, for indirect modes (LDI/STI), performs the pointer fetch itself over a memory-read handshake with timeout. It sits between the control FSM (request side) and the MAR load path (result side).

## Interface
- `DATA_W`, 16: address/data width; legal values are ≥16. Offsets are extended to `DATA_W`.
- `TIMEOUT_CYC`, 15: maximum number of cycles spent waiting for `mem_rd_valid`. Legal range is 1..255.
- `Clk`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: unit can accept a request.
- `IR`, in, 16: instruction word, sampled on accept.
- `PC`, in, `DATA_W`: base 0, sampled on accept.
- `SR1`, in, `DATA_W`: base 1, sampled on accept.
- `base_sel`, in, 1: selects the base. 0 = PC, 1 = SR1.
- `off_sel`, in, 3: offset select (encodings below).
- `indirect`, in, 1: when 1, the computed sum is a pointer address and is fetched.
- `mem_rd_req`, out, 1: pointer read request, level-held.
- `mem_addr`, out, `DATA_W`: pointer address.
- `mem_rd_valid`, in, 1: one-cycle pulse that returns `mem_rdata`.
- `mem_rdata`, in, `DATA_W`: fetched pointer.
- `out_valid`, out, 1: EA available.
- `out_ready`, in, 1: consumer accepts the EA.
- `out_addr`, out, `DATA_W`: effective address.
- `out_err`, out, 1: pointer fetch timed out. Qualified by `out_valid`.

## Operation
- Offset encodings for `off_sel`:
  - 0: zero.
  - 1: sext IR[4:0].
  - 2: sext IR[5:0].
  - 3: sext IR[8:0].
  - 4: sext IR[10:0].
  - 5: zext IR[7:0] (trap vector). The base is forced to 0 and `indirect` still applies.
  - 6, 7: reserved; treated as zero.
- Sum: base + offset, modulo 2^`DATA_W`. Carry-out is discarded.
- States: IDLE, CALC, MREQ, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, register IR, bases, selects and `indirect`, then go to CALC.
  - CALC: register the sum. If `indirect`=1, go to MREQ and clear the timeout counter; otherwise go to DONE with `out_addr`=sum and `out_err`=0.
  - MREQ: `mem_rd_req`=1 and `mem_addr`=registered sum, both held stable; the counter increments each cycle. On `mem_rd_valid`, go to DONE with `out_addr`=`mem_rdata` and `out_err`=0. If the counter reaches `TIMEOUT_CYC` without a valid, go to DONE with `out_addr`=pointer address and `out_err`=1.
  - DONE: `out_valid`=1; `out_addr` and `out_err` are held stable. On `out_ready`, go to IDLE.
- `mem_rd_valid` outside MREQ is ignored.
- If `mem_rd_valid` arrives in the same cycle the counter hits the limit, the data wins and `out_err`=0.
- `in_ready` is 0 outside IDLE, so inputs are don't-care there.
- Reset in any state: next cycle the unit is in IDLE, and any in-flight request or fetch is dropped.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0, `mem_rd_req`=0, `out_err`=0.
  - `out_addr`=0, `mem_addr`=0.
  - Counter=0.
- Direct mode: accept at edge N, `out_valid` high after edge N+2. Minimum occupancy is 3 cycles per request.
- Indirect mode: `mem_rd_req` rises after edge N+2. `out_valid` rises the edge after the `mem_rd_valid` cycle. On timeout, `out_valid` rises `TIMEOUT_CYC` cycles after `mem_rd_req` rises.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `slc3_agu_pkg` holds:
  - the `agu_state_t` enum (IDLE/CALC/MREQ/DONE);
  - localparams `OFF_ZERO`, `OFF_SEXT5`, `OFF_SEXT6`, `OFF_SEXT9`, `OFF_SEXT11`, `OFF_ZEXT8`;
  - the `base_sel` encodings.
- One sub-module, `agu_offset_ext`: combinational IR-field extraction and sign/zero extension to `DATA_W`, selected by `off_sel`. The FSM, adder, counter and handshake live in the top module.

## Test plan
- Direct, PC base: PC=0x3000, IR[8:0]=0x1FF, `off_sel`=3 → `out_addr`=0x2FFF, `out_err`=0, `out_valid` after 2 edges.
- Wrap and trap:
  - SR1=0xFFFF, IR[4:0]=0x01, `off_sel`=1 → 0x0000.
  - IR[7:0]=0x25, `off_sel`=5, PC=0x4000 → 0x0025.
- Indirect success: PC=0x3000, IR[10:0]=0x010, `off_sel`=4, `indirect`=1.
  - Expect `mem_addr`=0x3010 held.
  - Return `mem_rdata`=0x4ABC after 3 cycles → `out_addr`=0x4ABC, `out_err`=0.
- Timeout: `TIMEOUT_CYC`=4, no `mem_rd_valid` → `out_valid` with `out_addr`=pointer address and `out_err`=1. A second run drives `mem_rd_valid` on the limit cycle → `out_err`=0.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles → `out_addr` stays stable and `in_ready`=0.
  - Assert `Reset` during MREQ → next cycle `mem_rd_req`=0, `in_ready`=1, `out_valid`=0.
- Reserved and stray inputs:
  - `off_sel`=6 with SR1=0x1234 → 0x1234.
  - A stray `mem_rd_valid` in IDLE causes no state change.
